riscv_core_wb_arb: RTL

RISCV_CORE_WB_ARB -- requirements
Module: riscv_core_wb_arb

---
 rtl/riscv_core_pkg.sv | 24 ++
 rtl/riscv_core_wb_fifo.sv | 53 +++++
 rtl/riscv_core_wb_arb.sv | 100 ++++++++++
 3 files changed

// File: rtl/riscv_core_pkg.sv
// Shared definitions for the core writeback path: register-file geometry,
// the buffered writeback entry and a destination-decode helper.
package riscv_core_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int XLEN     = 32;

  // One buffered writeback: destination register and the value to write.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

  // Decode a destination into a one-hot register mask; x0 never appears.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    logic [NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    v[0]  = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/riscv_core_wb_fifo.sv
// Small result FIFO for multi-cycle MUL/DIV writebacks.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without an occupancy counter. Storage is not reset; only the pointers are.
module riscv_core_wb_fifo
  import riscv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  wb_entry_t i_entry,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output wb_entry_t o_head
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A full FIFO refuses pushes outright, even if it pops this cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  assign o_head = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Entry storage written at the write pointer.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
  end

endmodule

// File: rtl/riscv_core_wb_arb.sv
// Register-file writeback arbiter. The pipeline port has absolute priority
// and is forwarded combinationally; MUL/DIV results queue in a small FIFO
// and drain whenever the pipeline port is idle.
// Optional scoreboard of outstanding MDU destinations is built when macro
// RISCV_WB_SCOREBOARD_EN is defined; otherwise o_wb_pending is tied to 0.
module riscv_core_wb_arb
  import riscv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_wb_pipe_we,
  input  logic [4:0]  i_wb_pipe_rd,
  input  logic [31:0] i_wb_pipe_wd,
  input  logic        i_wb_mdu_valid,
  input  logic [4:0]  i_wb_mdu_rd,
  input  logic [31:0] i_wb_mdu_wd,
  output logic        o_wb_mdu_ready,
  input  logic        i_wb_issue_valid,
  input  logic [4:0]  i_wb_issue_rd,
  output logic [31:0] o_wb_pending,
  output logic        o_wb_rf_we3,
  output logic [4:0]  o_wb_rf_a3,
  output logic [31:0] o_wb_rf_wd3
);

  logic      w_pipe_act;
  logic      w_fifo_full;
  logic      w_fifo_empty;
  logic      w_push;
  logic      w_pop;
  wb_entry_t w_push_entry;
  wb_entry_t w_head;

  // Writes to x0 from the pipeline are no-ops and leave the slot to the FIFO.
  assign w_pipe_act = i_wb_pipe_we & (i_wb_pipe_rd != 5'd0);

  assign o_wb_mdu_ready  = ~w_fifo_full;
  assign w_push          = i_wb_mdu_valid & ~w_fifo_full;
  assign w_pop           = ~w_pipe_act & ~w_fifo_empty;
  assign w_push_entry.rd = i_wb_mdu_rd;
  assign w_push_entry.wd = i_wb_mdu_wd;

  riscv_core_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_wb_clk),
    .i_rst_n (i_wb_rst_n),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_head)
  );

  // Write-port mux: pipeline first, then FIFO head; an x0 head is popped silently.
  always_comb begin
    o_wb_rf_we3 = 1'b0;
    o_wb_rf_a3  = 5'd0;
    o_wb_rf_wd3 = 32'd0;
    if (w_pipe_act) begin
      o_wb_rf_we3 = 1'b1;
      o_wb_rf_a3  = i_wb_pipe_rd;
      o_wb_rf_wd3 = i_wb_pipe_wd;
    end else if (!w_fifo_empty && (w_head.rd != 5'd0)) begin
      o_wb_rf_we3 = 1'b1;
      o_wb_rf_a3  = w_head.rd;
      o_wb_rf_wd3 = w_head.wd;
    end
  end

`ifdef RISCV_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pend_set;
  logic [NUM_REGS-1:0] w_pend_clr;

  // Set on issue, clear on pop of a matching entry; x0 is masked by the decoder.
  always_comb begin
    w_pend_set = '0;
    w_pend_clr = '0;
    if (i_wb_issue_valid) w_pend_set = rd_onehot(i_wb_issue_rd);
    if (w_pop)            w_pend_clr = rd_onehot(w_head.rd);
  end

  // Scoreboard register; a same-cycle set overrides the clear.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) r_pending <= '0;
    else             r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
  end

  assign o_wb_pending = r_pending;
`else
  logic w_unused_issue;
  assign w_unused_issue = ^{i_wb_issue_valid, i_wb_issue_rd};
  assign o_wb_pending   = 32'd0;
`endif

endmodule
